// File: rtl/ifmt_exec_seq.sv
// ifmt_exec_seq: execute sequencer for uPower I-format ops (ADDI/ADDIS/ANDI/ORI) over a single-port regfile.
// Latency: done 4 cycles after accept (3 when rs==0 under UPOWER_RA0_ZERO_EN), 1 cycle for illegal opcodes.
// Backpressure: instr_ready only in IDLE, so one instruction in flight; the UPOWER_RA0_ZERO_EN macro makes rs==0 a literal zero operand.
module ifmt_exec_seq #(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  output logic [RF_AW-1:0] rf_addr,
  output logic             rf_we,
  output logic [XLEN-1:0]  rf_wdata,
  input  logic [XLEN-1:0]  rf_rdata,
  output logic             done,
  output logic             illegal,
  output logic [XLEN-1:0]  result
);

  localparam logic [5:0] OP_ADDI  = 6'd14;
  localparam logic [5:0] OP_ADDIS = 6'd15;
  localparam logic [5:0] OP_ANDI  = 6'd28;
  localparam logic [5:0] OP_ORI   = 6'd24;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_CAP, WR, DONE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [5:0]      op_q;
  logic [4:0]      rs_q;
  logic [4:0]      rt_q;
  logic [15:0]     imm_q;
  logic            illegal_q;
  logic [XLEN-1:0] result_q;
  logic            accept;
  logic            in_legal;
  logic [XLEN-1:0] operand;
  logic [XLEN-1:0] imm_sext;
  logic [XLEN-1:0] alu;

  assign in_legal = instr[31:26] inside {OP_ADDI, OP_ADDIS, OP_ANDI, OP_ORI};
  assign accept   = reset && (state == IDLE) && instr_valid;
  assign imm_sext = {{(XLEN-16){imm_q[15]}}, imm_q};

`ifdef UPOWER_RA0_ZERO_EN
  // r0 as a source reads as literal zero; the regfile data is not looked at
  assign operand = (rs_q == 5'd0) ? '0 : rf_rdata;
`else
  assign operand = rf_rdata;
`endif

  // Immediate ALU; wraps modulo 2^XLEN
  always_comb begin
    alu = '0;
    case (op_q)
      OP_ADDI:  alu = operand + imm_sext;
      OP_ADDIS: alu = operand + (imm_sext << 16);
      OP_ANDI:  alu = operand & XLEN'(imm_q);
      OP_ORI:   alu = operand | XLEN'(imm_q);
      default:  alu = '0;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Latch instruction fields on accept; capture the ALU result while read data is valid
  always_ff @(posedge clock) begin
    if (!reset) begin
      op_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      imm_q     <= '0;
      illegal_q <= 1'b0;
      result_q  <= '0;
    end else if (accept) begin
      op_q      <= instr[31:26];
      rs_q      <= instr[25:21];
      rt_q      <= instr[20:16];
      imm_q     <= instr[15:0];
      illegal_q <= !in_legal;
      result_q  <= '0;
    end else if (state == RD_CAP) begin
      result_q  <= alu;
    end
  end

  // Next state and regfile/handshake outputs; everything forced low while reset is asserted
  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    rf_addr     = '0;
    rf_we       = 1'b0;
    rf_wdata    = '0;
    done        = 1'b0;
    illegal     = 1'b0;
    result      = result_q;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          if (!in_legal) state_nxt = DONE;
`ifdef UPOWER_RA0_ZERO_EN
          else if (instr[25:21] == 5'd0) state_nxt = RD_CAP;
`endif
          else state_nxt = RD_REQ;
        end
      end
      RD_REQ: begin
        rf_addr   = RF_AW'(rs_q);
        state_nxt = RD_CAP;
      end
      RD_CAP: state_nxt = WR;
      WR: begin
        rf_addr   = RF_AW'(rt_q);
        rf_we     = 1'b1;
        rf_wdata  = result_q;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        illegal   = illegal_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!reset) begin
      state_nxt   = IDLE;
      instr_ready = 1'b0;
      rf_addr     = '0;
      rf_we       = 1'b0;
      rf_wdata    = '0;
      done        = 1'b0;
      illegal     = 1'b0;
      result      = '0;
    end
  end

endmodule

// File: tb/tb_ifmt_exec_seq.sv
// tb_ifmt_exec_seq: randomized and directed bench for ifmt_exec_seq with a registered-read regfile.
// Latency: n/a (testbench).
// Backpressure: n/a; instructions are offered and held until instr_ready.
module tb_ifmt_exec_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_ready;
  logic [4:0]  rf_addr;
  logic        rf_we;
  logic [31:0] rf_wdata;
  logic [31:0] rf_rdata;
  logic        done;
  logic        illegal;
  logic [31:0] result;

  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];
  logic        load_en = 1'b0;
  logic [4:0]  load_addr = '0;
  logic [31:0] load_data = '0;

  int checks = 0;
  int failures = 0;

  ifmt_exec_seq #(.XLEN(32), .RF_AW(5)) dut (
    .clock       (clock),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .rf_addr     (rf_addr),
    .rf_we       (rf_we),
    .rf_wdata    (rf_wdata),
    .rf_rdata    (rf_rdata),
    .done        (done),
    .illegal     (illegal),
    .result      (result)
  );

  always #5 clock = ~clock;

  // Single-port regfile: write on the edge, read data registered one cycle after address
  always @(posedge clock) begin
    if (load_en)    mem[load_addr] <= load_data;
    else if (rf_we) mem[rf_addr]   <= rf_wdata;
    rf_rdata <= mem[rf_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc(input int op, input int rs, input int rt, input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  // Reference: instruction semantics in plain arithmetic over ref_mem
  function automatic void ref_exec(input logic [31:0] ins, output bit legal,
                                   output logic [31:0] res, output int lat);
    int unsigned op;
    int unsigned imm;
    int unsigned a;
    int unsigned sx;
    op  = ins[31:26];
    imm = ins[15:0];
    a   = ref_mem[ins[25:21]];
    lat = 4;
`ifdef UPOWER_RA0_ZERO_EN
    if (ins[25:21] == 5'd0) begin a = 0; lat = 3; end
`endif
    sx = imm;
    if (imm >= 32'h8000) sx = sx - 32'h10000;
    legal = 1'b1;
    case (op)
      14: res = a + sx;
      15: res = a + imm * 65536;
      28: res = a & imm;
      24: res = a | imm;
      default: begin legal = 1'b0; res = 0; lat = 1; end
    endcase
  endfunction

  task automatic load_reg(input int a, input logic [31:0] v);
    @(negedge clock);
    load_en = 1'b1; load_addr = a[4:0]; load_data = v;
    @(posedge clock);
    #1 load_en = 1'b0;
    ref_mem[a] = v;
  endtask

  // Issue one instruction and observe it until done (bounded); lat=-1 if it never completes
  task automatic run_instr(input logic [31:0] ins, output int lat, output logic ill,
                           output logic [31:0] res, output int nwr,
                           output logic [4:0] waddr, output logic [31:0] wdata);
    int w;
    lat = -1; ill = 1'b0; res = '0; nwr = 0; waddr = '0; wdata = '0;
    @(negedge clock);
    instr = ins; instr_valid = 1'b1;
    w = 0;
    while (instr_ready !== 1'b1 && w < 20) begin @(negedge clock); w++; end
    if (instr_ready !== 1'b1) begin instr_valid = 1'b0; return; end
    @(posedge clock);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      instr_valid = 1'b0;
      instr = $urandom();
      if (rf_we === 1'b1) begin nwr++; waddr = rf_addr; wdata = rf_wdata; end
      if (done === 1'b1) begin lat = c; ill = illegal; res = result; break; end
    end
  endtask

  task automatic test_reset();
    instr = 32'h38220005; instr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks++;
      if ({instr_ready, rf_we, done, illegal, rf_addr, rf_wdata, result} !== '0) begin
        failures++;
        $display("FAIL reset_outputs ready=%b we=%b done=%b ill=%b addr=%0d wdata=%0d result=%0d required all 0",
                 instr_ready, rf_we, done, illegal, rf_addr, rf_wdata, result);
      end
    end
    @(negedge clock);
    reset = 1'b1; instr_valid = 1'b0;
    #1;
    checks++;
    if (instr_ready !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_release ready=%b done=%b required ready=1 done=0", instr_ready, done);
    end
  endtask

  task automatic test_plan();
    logic [31:0] pi [5] = '{32'h38220005, 32'h3822FFFF, 32'h702300F0, 32'h60240003, 32'h3C250001};
    logic [31:0] pe [5] = '{32'd217, 32'd211, 32'd208, 32'd215, 32'd65748};
    int lat; logic ill; logic [31:0] res; int nwr; logic [4:0] wa; logic [31:0] wd;
    logic [31:0] cur;
    logic [4:0] rt;
    for (int k = 0; k < 5; k++) begin
      cur = pi[k];
      rt = cur[20:16];
      run_instr(cur, lat, ill, res, nwr, wa, wd);
      ref_mem[rt] = pe[k];
      checks++;
      if (lat !== 4 || ill !== 1'b0 || res !== pe[k]) begin
        failures++;
        $display("FAIL plan%0d_done lat=%0d ill=%b result=%0d required lat=4 ill=0 result=%0d", k, lat, ill, res, pe[k]);
      end
      checks++;
      if (nwr !== 1 || wa !== rt || wd !== pe[k] || mem[rt] !== pe[k]) begin
        failures++;
        $display("FAIL plan%0d_write nwr=%0d addr=%0d data=%0d reg=%0d required 1/%0d/%0d/%0d",
                 k, nwr, wa, wd, mem[rt], rt, pe[k], pe[k]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ins [2] = '{32'h00000000, 32'hFC22FFFF};
    int lat; logic ill; logic [31:0] res; int nwr; logic [4:0] wa; logic [31:0] wd;
    int diffs;
    for (int k = 0; k < 2; k++) begin
      run_instr(ins[k], lat, ill, res, nwr, wa, wd);
      checks++;
      if (lat !== 1 || ill !== 1'b1 || res !== 32'd0 || nwr !== 0) begin
        failures++;
        $display("FAIL illegal%0d lat=%0d ill=%b result=%0d writes=%0d required 1/1/0/0", k, lat, ill, res, nwr);
      end
      diffs = 0;
      for (int r = 0; r < 32; r++) if (mem[r] !== ref_mem[r]) diffs++;
      checks++;
      if (diffs !== 0) begin
        failures++;
        $display("FAIL illegal%0d_regfile changed=%0d required 0", k, diffs);
      end
    end
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    int nwe = 0;
    @(negedge clock);
    instr = 32'h38220005; instr_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    instr_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (instr_ready !== 1'b0 || done !== 1'b0 || rf_we !== 1'b0) begin
      failures++;
      $display("FAIL midreset_low ready=%b done=%b we=%b required 0/0/0", instr_ready, done, rf_we);
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_ready ready=%b required 1", instr_ready);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (done === 1'b1) ndone++;
      if (rf_we === 1'b1) nwe++;
    end
    checks++;
    if (ndone !== 0 || nwe !== 0 || mem[2] !== ref_mem[2]) begin
      failures++;
      $display("FAIL midreset_drop done=%0d we=%0d r2=%0d required 0/0/%0d", ndone, nwe, mem[2], ref_mem[2]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a_ins;
    logic [31:0] b_ins;
    int acc [2] = '{-1, -1};
    int n = 0;
    bit lg; logic [31:0] r; int l;
    a_ins = enc(14, 1, 6, 3);
    b_ins = enc(14, 6, 7, 1);
    @(negedge clock);
    instr = a_ins; instr_valid = 1'b1;
    for (int c = 0; c < 40 && n < 2; c++) begin
      if (instr_ready === 1'b1) begin acc[n] = c; n++; end
      @(negedge clock);
      if (n == 1) instr = b_ins;
      else if (n == 2) instr_valid = 1'b0;
    end
    for (int c = 0; c < 8; c++) @(negedge clock);
    ref_exec(a_ins, lg, r, l); ref_mem[6] = r;
    ref_exec(b_ins, lg, r, l); ref_mem[7] = r;
    checks++;
    if (n !== 2 || acc[1] - acc[0] !== 5) begin
      failures++;
      $display("FAIL b2b_spacing accepted=%0d spacing=%0d required 2/5", n, acc[1] - acc[0]);
    end
    checks++;
    if (mem[6] !== ref_mem[6] || mem[7] !== ref_mem[7]) begin
      failures++;
      $display("FAIL b2b_regs r6=%0d r7=%0d required %0d/%0d", mem[6], mem[7], ref_mem[6], ref_mem[7]);
    end
  endtask

  task automatic test_ra0();
    int lat; logic ill; logic [31:0] res; int nwr; logic [4:0] wa; logic [31:0] wd;
    int exp_lat;
    logic [31:0] exp_r;
`ifdef UPOWER_RA0_ZERO_EN
    exp_lat = 3; exp_r = 32'd7;
`else
    exp_lat = 4; exp_r = 32'd106;
`endif
    load_reg(0, 32'd99);
    run_instr(32'h38020007, lat, ill, res, nwr, wa, wd);
    ref_mem[2] = exp_r;
    checks++;
    if (lat !== exp_lat || res !== exp_r || mem[2] !== exp_r) begin
      failures++;
      $display("FAIL ra0 lat=%0d result=%0d r2=%0d required lat=%0d value=%0d", lat, res, mem[2], exp_lat, exp_r);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [4] = '{6'd14, 6'd15, 6'd28, 6'd24};
    int lat; logic ill; logic [31:0] res; int nwr; logic [4:0] wa; logic [31:0] wd;
    bit lg; logic [31:0] er; int el;
    logic [31:0] ins;
    int op;
    for (int k = 0; k < 40; k++) begin
      op = ($urandom_range(0, 4) == 4) ? int'($urandom_range(0, 63)) : int'(ops[$urandom_range(0, 3)]);
      ins = enc(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535));
      ref_exec(ins, lg, er, el);
      run_instr(ins, lat, ill, res, nwr, wa, wd);
      checks++;
      if (lat !== el || ill !== !lg || res !== er) begin
        failures++;
        $display("FAIL rand%0d_done ins=%08h lat=%0d ill=%b result=%08h required %0d/%b/%08h",
                 k, ins, lat, ill, res, el, !lg, er);
      end
      checks++;
      if (nwr !== (lg ? 1 : 0)) begin
        failures++;
        $display("FAIL rand%0d_wcount ins=%08h writes=%0d required %0d", k, ins, nwr, lg ? 1 : 0);
      end
      if (lg) begin
        ref_mem[ins[20:16]] = er;
        checks++;
        if (wa !== ins[20:16] || wd !== er || mem[ins[20:16]] !== er) begin
          failures++;
          $display("FAIL rand%0d_write ins=%08h addr=%0d data=%08h reg=%08h required %0d/%08h",
                   k, ins, wa, wd, mem[ins[20:16]], ins[20:16], er);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    for (int r = 0; r < 32; r++) load_reg(r, $urandom());
    load_reg(1, 32'd212);
    load_reg(0, 32'd99);
    test_reset();
    test_plan();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    test_ra0();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifmt_exec_seq.md
Name: ifmt_exec_seq

Overview:
- Execute sequencer for uPower I-format instructions.
- Sits between the I-format field decoder and the single-port register file.
- Takes one instruction at a time. Reads the source register, applies the immediate operation, writes the destination register, then reports completion.
- Replaces hand-sequenced regfile traffic with a fixed-latency FSM.

Parameters:
- XLEN, 32, datapath and register width.
- RF_AW, 5, register file address width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- instr_valid  in  1  instr holds a new instruction.
- instr  in  32  instruction word. Opcode [31:26], rs [25:21], rt [20:16], imm [15:0].
- instr_ready  out  1  sequencer can accept an instruction.
- rf_addr  out  RF_AW  register file address.
- rf_we  out  1  register file write enable.
- rf_wdata  out  XLEN  register file write data.
- rf_rdata  in  XLEN  register file read data, valid 1 cycle after the address is sampled with rf_we=0.
- done  out  1  one-cycle completion pulse.
- illegal  out  1  completed instruction had an unsupported opcode; valid with done.
- result  out  XLEN  value written to rt; valid with done.

Behaviour:
- Interface: clock clock; reset reset, synchronous, active-low.
- While reset=0, on each rising edge: state=IDLE, result=0, latched fields=0.
- While reset=0, all outputs are 0 combinationally: instr_ready, rf_addr, rf_we, rf_wdata, done, illegal, result. rf_we is gated by reset so no write can occur on a reset edge.
- States: IDLE, RD_REQ, RD_CAP, WR, DONE. instr_ready=1 only in IDLE with reset=1.
- IDLE:
  - Acceptance is instr_valid & instr_ready at a rising edge.
  - On acceptance, latch opcode/rs/rt/imm.
  - Legal opcode -> RD_REQ. Illegal opcode -> DONE with illegal flag set.
- RD_REQ: rf_addr=rs, rf_we=0 -> RD_CAP.
- RD_CAP: compute from rf_rdata; register result -> WR.
- WR: rf_addr=rt, rf_we=1, rf_wdata=result -> DONE.
- DONE: done=1; illegal=1 if flagged; result held -> IDLE.
- Opcodes:
  - 14 ADDI: rs + sign-extend(imm).
  - 15 ADDIS: rs + {imm,16'b0}.
  - 28 ANDI: rs & zero-extend(imm).
  - 24 ORI: rs | zero-extend(imm).
  - All other opcodes are illegal.
- Arithmetic wraps modulo 2^XLEN. No carry or overflow output.
- Latency, counted from the accept edge:
  - Legal: done high in the 4th cycle.
  - Illegal: done high in the 1st cycle; no regfile access; result=0.
- Throughput: next acceptance is possible at the edge ending DONE+1 (IDLE). Back-to-back with instr_valid held high: one instruction per 5 cycles (legal).
- rf_addr is 0 and rf_we is 0 in IDLE and DONE.
- rs==rt is legal: read precedes write, so the result uses the old value.
- Reset mid-operation (any state): FSM returns to IDLE. No write occurs, no done pulse. The pending instruction is dropped.
- instr/instr_valid changes outside the accept edge are ignored.

Optional Feature:
- Macro: UPOWER_RA0_ZERO_EN.
- Defined: rs==0 is a literal 0 operand, per PowerPC addi/addis semantics.
  - Acceptance with rs==0 goes IDLE -> RD_CAP, skipping RD_REQ. rf_rdata is ignored and operand=0.
  - done is high in the 3rd cycle.
  - ANDI/ORI follow the same rule.
- Undefined: r0 is read like any other register; latency is always 4.

Test Plan:
- Preload r1=212. Instr 0x38220005 (ADDI rt=2 rs=1 imm=5) -> r2=217, result=217, done exactly 4 cycles after accept, rf_we high for 1 cycle with rf_addr=2.
- r1=212. 0x3822FFFF -> r2=211 (sign-extended -1).
- r1=212:
  - 0x702300F0 (ANDI) -> r3=208.
  - 0x60240003 (ORI) -> r4=215.
  - 0x3C250001 (ADDIS) -> r5=65748.
- 0x00000000 -> done 1 cycle after accept, illegal=1, result=0; rf_we never asserted, regfile unchanged.
- Accept 0x38220005, pull reset low during RD_CAP for 1 cycle -> r2 unchanged, no done pulse, instr_ready=1 after reset releases. Then hold instr_valid high with two ADDIs -> accepts 5 cycles apart.
- Under UPOWER_RA0_ZERO_EN, r0=99, 0x38020007 (rs=0, rt=2) -> r2=7, done 3 cycles after accept. Without the macro -> r2=106, latency 4.
